stack_param: RTL and testbench

STACK_PARAM -- requirements
Module: stack_param

---
 rtl/stack_param_if.sv | 38 +++
 rtl/stack_param.sv | 81 ++++++++
 tb/tb_stack_param.sv | 119 +++++++++++
 3 files changed

// File: rtl/stack_param_if.sv
// rtl/stack_param_if.sv - stack_param op/data bus; swap present only under STACK_SWAP_EN
interface stack_param_if #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8,
   parameter int CW    = $clog2(DEPTH + 1)
);
   logic             push;
   logic             pop;
   logic             load;
`ifdef STACK_SWAP_EN
   logic             swap;
`endif
   logic             clr_err;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] qtop;
   logic [WIDTH-1:0] qnext;
   logic [CW-1:0]    count;
   logic             empty;
   logic             full;
   logic             ovf;
   logic             unf;

   modport master (
`ifdef STACK_SWAP_EN
      output swap,
`endif
      output push, pop, load, clr_err, d,
      input  qtop, qnext, count, empty, full, ovf, unf
   );

   modport slave (
`ifdef STACK_SWAP_EN
      input  swap,
`endif
      input  push, pop, load, clr_err, d,
      output qtop, qnext, count, empty, full, ovf, unf
   );
endinterface

// File: rtl/stack_param.sv
// rtl/stack_param.sv - register-file LIFO stack with sticky ovf/unf; STACK_SWAP_EN adds swap
module stack_param #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               reset,
   stack_param_if.slave       bus
);
   logic [WIDTH-1:0] q [DEPTH];
   logic [CW-1:0]    count;
   logic             ovf;
   logic             unf;
   logic             is_empty;
   logic             is_full;
   logic             ovf_ev;
   logic             unf_ev;
   logic             do_swap;

`ifdef STACK_SWAP_EN
   assign do_swap = bus.swap & ~bus.push & ~bus.pop;
`else
   assign do_swap = 1'b0;
`endif

   assign is_empty = (count == '0);
   assign is_full  = (count == CW'(DEPTH));

   always_comb begin
      ovf_ev = bus.push & ~bus.pop & is_full;
      // Pop on empty covers both plain pop and replace-on-empty.
      unf_ev = (bus.pop & is_empty) | (do_swap & (count < CW'(2)));
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) q[i] <= '0;
         count <= '0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
      end else begin
         if (bus.push && bus.pop) begin
            q[0] <= bus.d;
            if (is_empty) count <= CW'(1);
         end else if (bus.push) begin
            q[0] <= bus.d;
            for (int i = 1; i < DEPTH; i++) q[i] <= q[i-1];
            if (!is_full) count <= count + CW'(1);
         end else if (bus.pop) begin
            if (!is_empty) begin
               for (int i = 0; i < DEPTH - 1; i++) q[i] <= q[i+1];
               q[DEPTH-1] <= '0;
               count      <= count - CW'(1);
            end
         end else if (do_swap) begin
            if (count >= CW'(2)) begin
               q[0] <= q[1];
               q[1] <= q[0];
            end
         end else if (bus.load) begin
            q[0] <= bus.d;
            if (is_empty) count <= CW'(1);
         end

         // A fresh error wins over a same-cycle clear.
         if (ovf_ev)           ovf <= 1'b1;
         else if (bus.clr_err) ovf <= 1'b0;
         if (unf_ev)           unf <= 1'b1;
         else if (bus.clr_err) unf <= 1'b0;
      end
   end

   assign bus.qtop  = q[0];
   assign bus.qnext = q[1];
   assign bus.count = count;
   assign bus.empty = is_empty;
   assign bus.full  = is_full;
   assign bus.ovf   = ovf;
   assign bus.unf   = unf;
endmodule

// File: tb/tb_stack_param.sv
// tb/tb_stack_param.sv - directed vector bench for stack_param (DEPTH=8, WIDTH=16)
module tb_stack_param;
   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   stack_param_if #(.WIDTH(16), .DEPTH(8)) bus ();
   stack_param #(.WIDTH(16), .DEPTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));

   typedef struct {
      string       name;
      logic        rst, push, pop, load, swp, clr;
      logic [15:0] d;
      logic [15:0] eq, en;
      logic [3:0]  ec;
      logic        ee, ef, eo, eu;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input string n, input logic r, pu, po, ld, sw, cl,
                      input logic [15:0] dd, eq, en, input logic [3:0] ec,
                      input logic ee, ef, eo, eu);
      vec_t v;
      v.name = n; v.rst = r; v.push = pu; v.pop = po; v.load = ld; v.swp = sw; v.clr = cl;
      v.d = dd; v.eq = eq; v.en = en; v.ec = ec; v.ee = ee; v.ef = ef; v.eo = eo; v.eu = eu;
      vecs.push_back(v);
   endtask

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      reset       = v.rst;
      bus.push    = v.push;
      bus.pop     = v.pop;
      bus.load    = v.load;
      bus.clr_err = v.clr;
      bus.d       = v.d;
`ifdef STACK_SWAP_EN
      bus.swap    = v.swp;
`endif
      @(posedge clk);
      #1;
      chk({v.name, ".qtop"},  32'(bus.qtop),  32'(v.eq));
      chk({v.name, ".qnext"}, 32'(bus.qnext), 32'(v.en));
      chk({v.name, ".count"}, 32'(bus.count), 32'(v.ec));
      chk({v.name, ".empty"}, 32'(bus.empty), 32'(v.ee));
      chk({v.name, ".full"},  32'(bus.full),  32'(v.ef));
      chk({v.name, ".ovf"},   32'(bus.ovf),   32'(v.eo));
      chk({v.name, ".unf"},   32'(bus.unf),   32'(v.eu));
   endtask

   initial begin
      reset = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.load = 1'b0;
      bus.clr_err = 1'b0; bus.d = '0;
`ifdef STACK_SWAP_EN
      bus.swap = 1'b0;
`endif
      //    name        rst pu po ld sw cl d        qtop     qnext    cnt  e  f  o  u
      add("reset",      0, 0, 0, 0, 0, 0, 16'h0,    16'h0,    16'h0,    0, 1, 0, 0, 0);
      add("push1111",   1, 1, 0, 0, 0, 0, 16'h1111, 16'h1111, 16'h0,    1, 0, 0, 0, 0);
      add("push2222",   1, 1, 0, 0, 0, 0, 16'h2222, 16'h2222, 16'h1111, 2, 0, 0, 0, 0);
      add("push3333",   1, 1, 0, 0, 0, 0, 16'h3333, 16'h3333, 16'h2222, 3, 0, 0, 0, 0);
      add("rst_push",   0, 1, 0, 0, 0, 0, 16'h4444, 16'h0,    16'h0,    0, 1, 0, 0, 0);
      for (int k = 1; k <= 8; k++)
         add($sformatf("fill%0d", k), 1, 1, 0, 0, 0, 0, 16'(k), 16'(k), 16'(k-1),
             4'(k), 0, (k == 8), 0, 0);
      add("push_full",  1, 1, 0, 0, 0, 0, 16'h9,    16'h9,    16'h8,    8, 0, 1, 1, 0);
      add("clr_ovf",    1, 0, 0, 0, 0, 1, 16'h0,    16'h9,    16'h8,    8, 0, 1, 0, 0);
      for (int j = 1; j <= 7; j++)
         add($sformatf("drain%0d", j), 1, 0, 1, 0, 0, 0, 16'h0, 16'(9-j),
             (j == 7) ? 16'h0 : 16'(8-j), 4'(8-j), 0, 0, 0, 0);
      add("drain_last", 1, 0, 1, 0, 0, 0, 16'h0,    16'h0,    16'h0,    0, 1, 0, 0, 0);
      add("pop_empty",  1, 0, 1, 0, 0, 0, 16'h0,    16'h0,    16'h0,    0, 1, 0, 0, 1);
      add("repl_empty", 1, 1, 1, 0, 0, 0, 16'hAAAA, 16'hAAAA, 16'h0,    1, 0, 0, 0, 1);
      add("clr_unf",    1, 0, 0, 0, 0, 1, 16'h0,    16'hAAAA, 16'h0,    1, 0, 0, 0, 0);
      add("load_top",   1, 0, 0, 1, 0, 0, 16'h5555, 16'h5555, 16'h0,    1, 0, 0, 0, 0);
      add("rst2",       0, 0, 0, 0, 0, 0, 16'h0,    16'h0,    16'h0,    0, 1, 0, 0, 0);
      add("push8",      1, 1, 0, 0, 0, 0, 16'h8,    16'h8,    16'h0,    1, 0, 0, 0, 0);
      add("push7",      1, 1, 0, 0, 0, 0, 16'h7,    16'h7,    16'h8,    2, 0, 0, 0, 0);
      add("pop7",       1, 0, 1, 0, 0, 0, 16'h0,    16'h8,    16'h0,    1, 0, 0, 0, 0);
      add("pop8",       1, 0, 1, 0, 0, 0, 16'h0,    16'h0,    16'h0,    0, 1, 0, 0, 0);
      add("pop_clr",    1, 0, 1, 0, 0, 1, 16'h0,    16'h0,    16'h0,    0, 1, 0, 0, 1);
      add("clr_only",   1, 0, 0, 0, 0, 1, 16'h0,    16'h0,    16'h0,    0, 1, 0, 0, 0);
      add("load_empty", 1, 0, 0, 1, 0, 0, 16'h1234, 16'h1234, 16'h0,    1, 0, 0, 0, 0);
      add("pushBEEF",   1, 1, 0, 0, 0, 0, 16'hBEEF, 16'hBEEF, 16'h1234, 2, 0, 0, 0, 0);
      add("replCAFE",   1, 1, 1, 0, 0, 0, 16'hCAFE, 16'hCAFE, 16'h1234, 2, 0, 0, 0, 0);
      add("push_ld",    1, 1, 0, 1, 0, 0, 16'h0042, 16'h0042, 16'hCAFE, 3, 0, 0, 0, 0);
      add("pop_ld",     1, 0, 1, 1, 0, 0, 16'h0099, 16'hCAFE, 16'h1234, 2, 0, 0, 0, 0);
`ifdef STACK_SWAP_EN
      add("s_rst",      0, 0, 0, 0, 0, 0, 16'h0,    16'h0,    16'h0,    0, 1, 0, 0, 0);
      add("s_push6",    1, 1, 0, 0, 0, 0, 16'h6,    16'h6,    16'h0,    1, 0, 0, 0, 0);
      add("s_push5",    1, 1, 0, 0, 0, 0, 16'h5,    16'h5,    16'h6,    2, 0, 0, 0, 0);
      add("swap2",      1, 0, 0, 0, 1, 0, 16'h0,    16'h6,    16'h5,    2, 0, 0, 0, 0);
      add("swap_ld",    1, 0, 0, 1, 1, 0, 16'hFFFF, 16'h5,    16'h6,    2, 0, 0, 0, 0);
      add("s_pop",      1, 0, 1, 0, 0, 0, 16'h0,    16'h6,    16'h0,    1, 0, 0, 0, 0);
      add("swap1",      1, 0, 0, 0, 1, 0, 16'h0,    16'h6,    16'h0,    1, 0, 0, 0, 1);
`endif
      foreach (vecs[i]) apply(vecs[i]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, errors=%0d", errors);
      $fatal(1);
   end
endmodule
